// File: rtl/gpu_pkg.sv
// ---------------------------------------------------------------------------
// gpu_pkg
// Shared definitions for the GPU coordinate datapath.
//   COORD_W     : width of one signed coordinate word
//   coord_t     : signed coordinate type
//   vsr_state_t : control states of the vertex stream reader
//   sat_coord() : saturates a coordinate into an inclusive [lo, hi] range
// No ports (package).
// ---------------------------------------------------------------------------
package gpu_pkg;

   localparam int COORD_W = 10;

   typedef logic signed [COORD_W-1:0] coord_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } vsr_state_t;

   // Both compares are signed because every operand is coord_t.
   function automatic coord_t sat_coord(input coord_t value,
                                        input coord_t lo,
                                        input coord_t hi);
      coord_t result;
      result = value;
      if (value < lo) begin
         result = lo;
      end else if (value > hi) begin
         result = hi;
      end
      return result;
   endfunction

endpackage

// File: rtl/vsr_bank.sv
// ---------------------------------------------------------------------------
// vsr_bank
// NUM_WORDS x WIDTH word store for the vertex stream reader.
// Synchronous write, asynchronous (combinational) read.
// Ports:
//   clk      in  1      rising-edge clock
//   rst      in  1      synchronous active-low reset, clears every word
//   we       in  1      write enable (already qualified by the caller)
//   wr_addr  in  AW     write index
//   wr_data  in  WIDTH  write word
//   rd_addr  in  AW     read index; indices >= NUM_WORDS read as zero
//   rd_data  out WIDTH  word at rd_addr
// ---------------------------------------------------------------------------
module vsr_bank
   import gpu_pkg::*;
#(
   parameter int WIDTH     = COORD_W,
   parameter int NUM_WORDS = 9,
   parameter int AW        = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   localparam logic [AW:0] NW = NUM_WORDS[AW:0];

   logic [WIDTH-1:0] mem [NUM_WORDS];

   // Storage: reset clears the whole bank so a burst after reset streams zeros.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // The reader looks one index ahead, so it can present an address just past
   // the last word; that lookup is masked to zero instead of reading off the end.
   always_comb begin
      rd_data = '0;
      if ({1'b0, rd_addr} < NW) begin
         rd_data = mem[rd_addr];
      end
   end

endmodule

// File: rtl/vertex_stream_reader.sv
// ---------------------------------------------------------------------------
// vertex_stream_reader
// Holds NUM_WORDS signed coordinate words written by a host port and, on a
// start pulse, drains them in index order onto a valid/ready stream.
// Optional feature macro: VERTEX_READER_CLAMP_EN
//   defined     -> streamed words are saturated to [CLAMP_MIN, CLAMP_MAX]
//   not defined -> streamed words are the raw stored values
// Ports:
//   clk       in  1      rising-edge clock
//   rst       in  1      synchronous active-low reset
//   wr_en     in  1      write strobe
//   wr_addr   in  AW     write index 0..NUM_WORDS-1
//   wr_data   in  WIDTH  word to store
//   start     in  1      begin a burst (accepted only when idle)
//   out_ready in  1      downstream accepts the current word
//   out_valid out 1      out_data/out_idx/out_last are valid
//   out_data  out WIDTH  current word
//   out_idx   out AW     index of current word
//   out_last  out 1      current word is the final index
//   busy      out 1      burst in progress
//   done      out 1      one-cycle pulse after the final word is accepted
//   wr_err    out 1      one-cycle pulse for a rejected write
// ---------------------------------------------------------------------------
module vertex_stream_reader
   import gpu_pkg::*;
#(
   parameter int WIDTH     = COORD_W,
   parameter int NUM_WORDS = 9,
   parameter int AW        = 4,
   parameter int CLAMP_MIN = -320,
   parameter int CLAMP_MAX = 319
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             start,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [AW-1:0]    out_idx,
   output logic             out_last,
   output logic             busy,
   output logic             done,
   output logic             wr_err
);

   localparam logic [AW:0]   NW       = NUM_WORDS[AW:0];
   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WORDS - 1);

   // Reject parameter sets the index logic cannot represent.
   if (NUM_WORDS < 2 || NUM_WORDS > 16 || (2 ** AW) < NUM_WORDS ||
       CLAMP_MIN > CLAMP_MAX) begin : g_bad_params
      $error("vertex_stream_reader: illegal parameter combination");
   end

   vsr_state_t       state;
   logic             addr_ok;
   logic             bank_we;
   logic [AW-1:0]    idx_next;
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] first_word;

`ifdef VERTEX_READER_CLAMP_EN
   localparam coord_t CMIN = CLAMP_MIN[COORD_W-1:0];
   localparam coord_t CMAX = CLAMP_MAX[COORD_W-1:0];

   // Saturation is applied on the way out; the bank keeps the raw value.
   // This path assumes WIDTH equals COORD_W.
   function automatic logic [WIDTH-1:0] shape_word(input logic [WIDTH-1:0] w);
      return sat_coord(coord_t'(w), CMIN, CMAX);
   endfunction
`else
   function automatic logic [WIDTH-1:0] shape_word(input logic [WIDTH-1:0] w);
      return w;
   endfunction
`endif

   // Writes are only accepted while idle and in range, so the bank is frozen
   // for the whole burst and the output registers never go stale.
   always_comb begin
      addr_ok  = ({1'b0, wr_addr} < NW);
      bank_we  = wr_en && addr_ok && (state == IDLE);
      idx_next = out_idx + 1'b1;
      rd_addr  = (state == STREAM) ? idx_next : '0;
   end

   vsr_bank #(
      .WIDTH     (WIDTH),
      .NUM_WORDS (NUM_WORDS),
      .AW        (AW)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (bank_we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   // A write to word 0 in the same cycle as start has not reached the bank yet
   // at that edge, so its data is forwarded straight into the first output word.
   always_comb begin
      first_word = rd_data;
      if (bank_we && (wr_addr == '0)) begin
         first_word = wr_data;
      end
   end

   // Control FSM with all stream outputs registered. out_idx doubles as the
   // burst index; the bank is read one index ahead so the next word is ready
   // to load on the edge that completes a transfer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         wr_err    <= 1'b0;
      end else begin
         done   <= 1'b0;
         wr_err <= wr_en && !bank_we;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= STREAM;
                  out_valid <= 1'b1;
                  out_idx   <= '0;
                  out_data  <= shape_word(first_word);
                  out_last  <= (LAST_IDX == '0);
                  busy      <= 1'b1;
               end
            end
            STREAM: begin
               if (out_ready) begin
                  if (out_last) begin
                     state     <= DONE;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     out_idx  <= idx_next;
                     out_data <= shape_word(rd_data);
                     out_last <= (idx_next == LAST_IDX);
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vertex_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_vertex_stream_reader
// Directed bench for vertex_stream_reader (NUM_WORDS=9, WIDTH=10, AW=4).
// Expected words are kept in a local table that mirrors what the bench has
// written; clamp expectations follow VERTEX_READER_CLAMP_EN.
// ---------------------------------------------------------------------------
module tb_vertex_stream_reader;

   localparam int WIDTH     = 10;
   localparam int NUM_WORDS = 9;
   localparam int AW        = 4;

   logic             clk;
   logic             rst;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             start;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [AW-1:0]    out_idx;
   logic             out_last;
   logic             busy;
   logic             done;
   logic             wr_err;

   int vectors;
   int miscompares;

   logic signed [WIDTH-1:0] exp_word [NUM_WORDS];

   vertex_stream_reader #(
      .WIDTH     (WIDTH),
      .NUM_WORDS (NUM_WORDS),
      .AW        (AW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .start     (start),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done),
      .wr_err    (wr_err)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                input logic [WIDTH-1:0] data, input logic st,
                                input logic rdy);
      wr_en     = we;
      wr_addr   = addr;
      wr_data   = data;
      start     = st;
      out_ready = rdy;
   endtask

   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // One full burst with out_ready high except for an optional 3-cycle stall
   // at index 4 and an optional rejected write to word 2 at index 1.
   task automatic runBurst(input bit stall, input bit wr_mid);
      start = 1'b1;
      tick();
      start     = 1'b0;
      wr_en     = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < NUM_WORDS; k++) begin
         checkOutput("valid", out_valid, 1);
         checkOutput("idx", out_idx, k);
         checkOutput("data", $signed(out_data), exp_word[k]);
         checkOutput("last", out_last, (k == NUM_WORDS - 1) ? 1 : 0);
         checkOutput("busy", busy, 1);
         checkOutput("done_in_burst", done, 0);
         if (stall && k == 4) begin
            out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               tick();
               checkOutput("stall_valid", out_valid, 1);
               checkOutput("stall_idx", out_idx, 4);
               checkOutput("stall_data", $signed(out_data), exp_word[4]);
               checkOutput("stall_last", out_last, 0);
            end
            out_ready = 1'b1;
         end
         if (wr_mid && k == 1) begin
            wr_en   = 1'b1;
            wr_addr = 4'd2;
            wr_data = 10'd99;
         end
         tick();
         if (wr_mid && k == 1) begin
            wr_en = 1'b0;
            checkOutput("wr_err_busy", wr_err, 1);
         end
      end
      checkOutput("end_valid", out_valid, 0);
      checkOutput("end_done", done, 1);
      checkOutput("end_busy", busy, 0);
      tick();
      checkOutput("done_pulse_len", done, 0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < NUM_WORDS; i++) exp_word[i] = '0;

      $display("[TB] reset");
      tick();
      tick();
      checkOutput("rst_valid", out_valid, 0);
      checkOutput("rst_data", $signed(out_data), 0);
      checkOutput("rst_idx", out_idx, 0);
      checkOutput("rst_last", out_last, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_wr_err", wr_err, 0);
      rst = 1'b1;
      tick();

      $display("[TB] burst of cleared bank");
      runBurst(1'b0, 1'b0);

      $display("[TB] load words and plain burst");
      for (int i = 0; i < NUM_WORDS; i++) begin
         exp_word[i] = 10'(-5 + 15 * i);
         applyStimulus(1'b1, AW'(i), exp_word[i], 1'b0, 1'b0);
         tick();
         checkOutput("wr_err_ok", wr_err, 0);
      end
      wr_en = 1'b0;
      runBurst(1'b0, 1'b0);

      $display("[TB] stall and rejected mid-burst write");
      runBurst(1'b1, 1'b1);

      $display("[TB] out-of-range write");
      applyStimulus(1'b1, 4'd12, 10'd77, 1'b0, 1'b0);
      tick();
      wr_en = 1'b0;
      checkOutput("wr_err_range", wr_err, 1);
      tick();
      checkOutput("wr_err_clear", wr_err, 0);
      runBurst(1'b0, 1'b0);

      $display("[TB] reset mid-burst");
      start     = 1'b1;
      out_ready = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      checkOutput("pre_rst_idx", out_idx, 5);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checkOutput("mid_rst_valid", out_valid, 0);
      checkOutput("mid_rst_busy", busy, 0);
      checkOutput("mid_rst_done", done, 0);
      tick();
      checkOutput("mid_rst_no_done", done, 0);
      for (int i = 0; i < NUM_WORDS; i++) exp_word[i] = '0;
      runBurst(1'b0, 1'b0);

      $display("[TB] clamp boundary words");
      applyStimulus(1'b1, 4'd1, 10'(-400), 1'b0, 1'b0);
      tick();
`ifdef VERTEX_READER_CLAMP_EN
      exp_word[0] = 10'(319);
      exp_word[1] = 10'(-320);
`else
      exp_word[0] = 10'(500);
      exp_word[1] = 10'(-400);
`endif
      // Word 0 is written in the same cycle as start.
      applyStimulus(1'b1, 4'd0, 10'(500), 1'b0, 1'b0);
      runBurst(1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
